// File: rtl/ofm_psum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ofm_psum_buffer
// Description : Partial-sum buffer between conv passes; drains final OFM data.
// Revision    : 1.0 - initial release
// ============================================================================
module ofm_psum_buffer #(
    parameter int DATA_WIDTH        = 32,
    parameter int NUMBER_OF_FILTERS = 160,
    parameter int OFM_PIXELS        = 1,
    parameter int NUMBER_OF_PASSES  = 8,
    localparam int D   = NUMBER_OF_FILTERS * OFM_PIXELS,
    localparam int AW  = (D > 1) ? $clog2(D) : 1,
    localparam int PCW = $clog2(NUMBER_OF_PASSES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  psum_rd_en,
    output logic [DATA_WIDTH-1:0] data_out_for_prev,
    input  logic                  drain_rd_en,
    output logic [DATA_WIDTH-1:0] ofm_data,
    output logic                  ofm_valid,
    output logic [PCW-1:0]        pass_count,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [AW-1:0]  LAST_ADDR = AW'(D - 1);
    localparam logic [PCW-1:0] LAST_PASS = PCW'(NUMBER_OF_PASSES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic [PCW-1:0]        pass_count_q, pass_count_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] ofm_data_q, ofm_data_d;
    logic                  ofm_valid_q, ofm_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q [D];

    assign mem_we = (state_q == ACCUM) && in_valid && !reset;

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr_q] <= data_in;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        pass_count_d = pass_count_q;
        prev_d       = prev_q;
        ofm_data_d   = ofm_data_q;
        ofm_valid_d  = 1'b0;
        overflow_d   = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wr_addr_d    = '0;
                    rd_addr_d    = '0;
                    pass_count_d = '0;
                    overflow_d   = 1'b0;
                    state_d      = ACCUM;
                end else if (in_valid) begin
                    overflow_d = 1'b1;
                end
            end
            ACCUM: begin
                // First pass feeds zero so the accumulator only adds bias.
                if (psum_rd_en) begin
                    prev_d    = (pass_count_q == '0) ? '0 : mem_q[rd_addr_q];
                    rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + AW'(1);
                end
                if (in_valid) begin
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d    = '0;
                        pass_count_d = pass_count_q + PCW'(1);
                        if (pass_count_q == LAST_PASS) begin
                            state_d   = DRAIN;
                            rd_addr_d = '0;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (in_valid) begin
                    overflow_d = 1'b1;
                end
                if (drain_rd_en) begin
                    ofm_data_d  = mem_q[rd_addr_q];
                    ofm_valid_d = 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_d = '0;
                        state_d   = DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            DONE: begin
                if (in_valid) begin
                    overflow_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            pass_count_q <= '0;
            prev_q       <= '0;
            ofm_data_q   <= '0;
            ofm_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            pass_count_q <= pass_count_d;
            prev_q       <= prev_d;
            ofm_data_q   <= ofm_data_d;
            ofm_valid_q  <= ofm_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign data_out_for_prev = prev_q;
    assign ofm_data          = ofm_data_q;
    assign ofm_valid         = ofm_valid_q;
    assign pass_count        = pass_count_q;
    assign overflow          = overflow_q;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_ofm_psum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofm_psum_buffer
// Description : Scoreboard bench for ofm_psum_buffer against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofm_psum_buffer;

    localparam int DW  = 32;
    localparam int NF  = 4;
    localparam int OP  = 1;
    localparam int NP  = 2;
    localparam int D   = NF * OP;
    localparam int PCW = $clog2(NP + 1);

    localparam int M_IDLE  = 0;
    localparam int M_ACCUM = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, psum_rd_en, drain_rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out_for_prev, ofm_data;
    logic          ofm_valid, busy, done, overflow;
    logic [PCW-1:0] pass_count;

    always #5 clk = ~clk;

    ofm_psum_buffer #(
        .DATA_WIDTH       (DW),
        .NUMBER_OF_FILTERS(NF),
        .OFM_PIXELS       (OP),
        .NUMBER_OF_PASSES (NP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .in_valid         (in_valid),
        .data_in          (data_in),
        .psum_rd_en       (psum_rd_en),
        .data_out_for_prev(data_out_for_prev),
        .drain_rd_en      (drain_rd_en),
        .ofm_data         (ofm_data),
        .ofm_valid        (ofm_valid),
        .pass_count       (pass_count),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] psum_exp_q[$];
    logic [DW-1:0] ofm_exp_q[$];

    // Behavioural model: the layer as a list of passes over D words.
    int            mode = M_IDLE;
    int            wr = 0, rd = 0, pc = 0;
    bit            ovf = 1'b0;
    logic [DW-1:0] mem_m [D];
    bit            f_psum = 1'b0, f_drain = 1'b0, f_rst = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit st, input bit iv, input logic [DW-1:0] din,
                              input bit prd, input bit drd, input bit rst);
        f_psum  = 1'b0;
        f_drain = 1'b0;
        f_rst   = rst;
        if (rst) begin
            mode = M_IDLE; wr = 0; rd = 0; pc = 0; ovf = 1'b0;
            return;
        end
        case (mode)
            M_IDLE: begin
                if (st) begin
                    wr = 0; rd = 0; pc = 0; ovf = 1'b0; mode = M_ACCUM;
                end else if (iv) begin
                    ovf = 1'b1;
                end
            end
            M_ACCUM: begin
                if (prd) begin
                    psum_exp_q.push_back((pc == 0) ? DW'(0) : mem_m[rd]);
                    f_psum = 1'b1;
                    rd = (rd + 1) % D;
                end
                if (iv) begin
                    mem_m[wr] = din;
                    wr = wr + 1;
                    if (wr == D) begin
                        wr = 0;
                        pc = pc + 1;
                        if (pc == NP) begin
                            mode = M_DRAIN;
                            rd = 0;
                        end
                    end
                end
            end
            M_DRAIN: begin
                if (iv) ovf = 1'b1;
                if (drd) begin
                    ofm_exp_q.push_back(mem_m[rd]);
                    f_drain = 1'b1;
                    rd = rd + 1;
                    if (rd == D) begin
                        rd = 0;
                        mode = M_DONE;
                    end
                end
            end
            default: begin
                if (iv) ovf = 1'b1;
                mode = M_IDLE;
            end
        endcase
    endtask

    task automatic cyc(input bit st, input bit iv, input logic [DW-1:0] din,
                       input bit prd, input bit drd, input bit rst);
        @(negedge clk);
        reset       = rst;
        start       = st;
        in_valid    = iv;
        data_in     = din;
        psum_rd_en  = prd;
        drain_rd_en = drd;
        model_step(st, iv, din, prd, drd, rst);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: expectations latched at the edge, compared just after it.
    initial begin
        logic [DW-1:0] last_psum;
        bit fp, fd, fr, e_busy, e_done, e_ovf;
        int e_pc;
        last_psum = '0;
        forever begin
            @(posedge clk);
            fp = f_psum; fd = f_drain; fr = f_rst;
            e_busy = (mode != M_IDLE);
            e_done = (mode == M_DONE);
            e_pc   = pc;
            e_ovf  = ovf;
            #1;
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("pass_count", pass_count, e_pc);
            chk("overflow", overflow, e_ovf);
            chk("ofm_valid", ofm_valid, fd);
            if (fr) begin
                last_psum = '0;
                chk("ofm_data_reset", ofm_data, 0);
            end
            if (fp) begin
                if (psum_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL psum_underflow: got %0h expected none", data_out_for_prev);
                end else begin
                    last_psum = psum_exp_q.pop_front();
                end
            end
            chk("data_out_for_prev", data_out_for_prev, last_psum);
            if (ofm_valid === 1'b1) begin
                if (ofm_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ofm_unexpected: got %0h expected none", ofm_data);
                end else begin
                    chk("ofm_data", ofm_data, ofm_exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; data_in = '0;
        psum_rd_en = 1'b0; drain_rd_en = 1'b0;
        model_step(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Scenario 1: first pass, stored psums read back as zero.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, DW'(i), 1, 0, 0);
        after_edge();
        chk("s1_pass_count", pass_count, 1);

        // Scenario 2: second pass then drain.
        for (int i = 1; i <= 4; i++) cyc(0, 1, DW'(i * 10), 1, 0, 0);
        after_edge();
        chk("s2_data_out_for_prev", data_out_for_prev, 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        after_edge();
        chk("s2_done", done, 1);
        chk("s2_last_ofm", ofm_data, 40);
        cyc(0, 0, 0, 0, 0, 0);
        after_edge();
        chk("s2_busy_fall", busy, 0);

        // Scenario 3: in_valid in IDLE is dropped and flagged.
        cyc(0, 1, 32'hDEAD, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        after_edge();
        chk("s3_overflow", overflow, 1);

        // Scenario 4: reset mid pass 1.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, DW'(50 + i), 1, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 1, DW'(60 + i), 1, 0, 0);
        cyc(0, 1, 32'h77, 1, 0, 1);
        after_edge();
        chk("s4_busy", busy, 0);
        chk("s4_pass_count", pass_count, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Scenario 5: same-cycle read and write at address 0.
        cyc(1, 0, 0, 0, 0, 0);
        after_edge();
        chk("s5_restart_pass", pass_count, 0);
        cyc(0, 1, 32'd5, 1, 0, 0);
        for (int i = 1; i < 4; i++) cyc(0, 1, DW'(100 + i), 1, 0, 0);
        cyc(0, 1, 32'd9, 1, 0, 0);
        after_edge();
        chk("s5_old_value", data_out_for_prev, 5);
        for (int i = 1; i < 4; i++) cyc(0, 1, DW'(200 + i), 1, 0, 0);

        // Scenario 6: start pulsed during drain has no effect.
        cyc(0, 0, 0, 0, 1, 0);
        after_edge();
        chk("s5_new_value", ofm_data, 9);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        after_edge();
        chk("s6_done", done, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Randomized layers: psum read paired with write, as the conv path does.
        for (int layer = 0; layer < 8; layer++) begin
            cyc(1, 0, 0, 0, 0, 0);
            for (int c = 0; c < 400 && mode != M_IDLE; c++) begin
                bit iv, drd, st, rst;
                iv  = ($urandom_range(2) != 0);
                drd = ($urandom_range(1) != 0);
                st  = ($urandom_range(9) == 0);
                rst = ($urandom_range(99) < 2);
                cyc(st, iv, DW'($urandom), iv, drd, rst);
            end
            cyc(0, 0, 0, 0, 0, 0);
        end

        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        after_edge();
        chk("psum_queue_empty", psum_exp_q.size(), 0);
        chk("ofm_queue_empty", ofm_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ofm_psum_buffer.md
OFM_PSUM_BUFFER -- requirements
Module: ofm_psum_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter NUMBER_OF_FILTERS, default 160, output channels per pixel.
REQ-003 SHALL have parameter OFM_PIXELS, default 1, output pixels per channel (IFM_SIZE_NEXT squared).
REQ-004 SHALL have parameter NUMBER_OF_PASSES, default 8, input-channel passes (IFM_DEPTH/NUMBER_OF_UNITS).
REQ-005 SHALL derive D = NUMBER_OF_FILTERS*OFM_PIXELS and AW = $clog2(D).
REQ-006 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, begin a layer; honoured only in IDLE.
- in_valid, in, 1, data_in carries one conv result (data_out_for_next of the conv datapath).
- data_in, in, DATA_WIDTH, partial or final sum.
- psum_rd_en, in, 1, conv controller requests the next stored partial sum.
- data_out_for_prev, out, DATA_WIDTH, partial sum to the accumulator data_in_from_next.
- drain_rd_en, in, 1, downstream reads a final result.
- ofm_data, out, DATA_WIDTH, final result.
- ofm_valid, out, 1, ofm_data valid.
- pass_count, out, $clog2(NUMBER_OF_PASSES+1), completed passes.
- busy, out, 1, state is not IDLE.
- done, out, 1, one-cycle pulse at drain completion.
- overflow, out, 1, sticky illegal-write flag.

Function
REQ-007 SHALL implement FSM states IDLE, ACCUM, DRAIN, DONE.
REQ-008 IDLE + start SHALL clear wr_addr, rd_addr, pass_count and overflow, then enter ACCUM next cycle.
REQ-009 ACCUM + in_valid SHALL write data_in to mem[wr_addr] at the clock edge, then increment wr_addr.
- When wr_addr = D-1, wr_addr wraps to 0 and pass_count increments.
REQ-010 A wrap with pass_count = NUMBER_OF_PASSES-1 SHALL enter DRAIN with rd_addr = 0.
REQ-011 ACCUM + psum_rd_en SHALL register mem[rd_addr] onto data_out_for_prev, 1-cycle latency; rd_addr increments and wraps at D-1 to 0.
REQ-012 While pass_count = 0, data_out_for_prev SHALL be 0 one cycle after psum_rd_en, so the first pass adds bias only.
REQ-013 psum_rd_en and in_valid to the same address in the same cycle SHALL return the old contents (read-before-write).
REQ-014 data_out_for_prev SHALL hold its value when psum_rd_en = 0.
REQ-015 DRAIN + drain_rd_en SHALL output mem[rd_addr] on ofm_data with ofm_valid = 1 the next cycle; rd_addr increments.
REQ-016 ofm_valid SHALL be 0 in every cycle not following an accepted drain_rd_en.
REQ-017 After the D-th drain read, the FSM SHALL enter DONE; done = 1 for exactly that cycle, then the FSM returns to IDLE.
REQ-018 in_valid in IDLE, DRAIN or DONE SHALL be ignored (no write) and SHALL set overflow.
REQ-019 psum_rd_en outside ACCUM and drain_rd_en outside DRAIN SHALL be ignored.
REQ-020 start while busy = 1 SHALL be ignored.
REQ-021 busy SHALL be 1 in ACCUM, DRAIN and DONE.
REQ-022 Stored data SHALL pass through without arithmetic; no width change, truncation or saturation.

Reset
REQ-023 reset SHALL force state IDLE and 0 on wr_addr, rd_addr, pass_count, data_out_for_prev, ofm_data, ofm_valid, done, overflow and busy at the next clock edge.
REQ-024 reset SHALL take priority over all inputs, including mid-ACCUM and mid-DRAIN.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-026 Scenario 1: D=4, PASSES=2. start, then psum_rd_en plus in_valid with 1,2,3,4. data_out_for_prev reads 0,0,0,0; pass_count becomes 1.
REQ-027 Scenario 2: continue with 10,20,30,40 and psum_rd_en. data_out_for_prev reads 1,2,3,4, then the FSM enters DRAIN; four drain_rd_en cycles give ofm_data 10,20,30,40, each with ofm_valid one cycle later; done pulses once; busy falls.
REQ-028 Scenario 3: in_valid in IDLE with data 0xDEAD. No write occurs; overflow = 1 until the next start.
REQ-029 Scenario 4: reset asserted after 2 of 4 writes in pass 1. Next cycle state is IDLE, all outputs 0; a new start begins again at pass 0.
REQ-030 Scenario 5: same-cycle psum_rd_en and in_valid at address 0 (old value 5, new value 9). data_out_for_prev = 5; a later read returns 9.
REQ-031 Scenario 6: start pulsed during DRAIN. No effect; the drain sequence and done timing are unchanged.
